// File: rtl/write_back_regfile_pkg.sv
// Shared widths and types for the write-back register file.
// Staging entry layout is shared by the top and the testbench.
package write_back_regfile_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
    localparam int CNT_W     = 16;
    localparam int REG_COUNT = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] ZERO_REG = '0;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    typedef struct packed {
        reg_idx_t  addr;
        reg_data_t data;
    } wb_stage_t;

    function automatic logic is_zero_reg(input reg_idx_t idx);
        return idx == ZERO_REG;
    endfunction

endpackage

// File: rtl/write_back_regfile_if.sv
// Write-back request and operand read bundle for the register file.
// Master drives requests and read indices; slave returns read data.
interface write_back_regfile_if
    import write_back_regfile_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_W
) ();

    logic                 RegWre;
    reg_idx_t             WriteReg;
    reg_data_t            WriteData;
    reg_idx_t             ReadReg1;
    reg_idx_t             ReadReg2;
    reg_data_t            ReadData1;
    reg_data_t            ReadData2;
    logic                 WbPending;
    logic [CNT_WIDTH-1:0] WbCount;

    modport master (
        output RegWre,
        output WriteReg,
        output WriteData,
        output ReadReg1,
        output ReadReg2,
        input  ReadData1,
        input  ReadData2,
        input  WbPending,
        input  WbCount
    );

    modport slave (
        input  RegWre,
        input  WriteReg,
        input  WriteData,
        input  ReadReg1,
        input  ReadReg2,
        output ReadData1,
        output ReadData2,
        output WbPending,
        output WbCount
    );

endinterface

// File: rtl/write_back_regfile_array.sv
// REG_COUNT x DATA_W storage: one synchronous write port,
// two asynchronous read ports, synchronous active-low clear.
module regfile_array
    import write_back_regfile_pkg::*;
(
    input  logic      CLK,
    input  logic      RST,
    input  logic      we,
    input  reg_idx_t  waddr,
    input  reg_data_t wdata,
    input  reg_idx_t  raddr1,
    input  reg_idx_t  raddr2,
    output reg_data_t rdata1,
    output reg_data_t rdata2
);

    reg_data_t mem [REG_COUNT];

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = mem[raddr1];
    assign rdata2 = mem[raddr2];

endmodule

// File: rtl/write_back_regfile.sv
// Register file with a one-deep write-back staging register.
// Reads bypass from staging so a captured write is visible next cycle.
module write_back_regfile
    import write_back_regfile_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_W
) (
    input  logic                 CLK,
    input  logic                 RST,
    write_back_regfile_if.slave  wb
);

    wb_stage_t            stage_q;
    logic                 pend_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic      capture;
    reg_data_t arr_rd1;
    reg_data_t arr_rd2;
    logic      zero1;
    logic      zero2;
    logic      hit1;
    logic      hit2;
    reg_data_t rd1;
    reg_data_t rd2;

    assign capture = wb.RegWre && !is_zero_reg(wb.WriteReg);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            stage_q <= '0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pend_q <= capture;
            if (capture) begin
                stage_q.addr <= wb.WriteReg;
                stage_q.data <= wb.WriteData;
            end
            if (pend_q) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Commit of the old staging entry runs alongside a new capture.
    regfile_array u_array (
        .CLK    (CLK),
        .RST    (RST),
        .we     (pend_q),
        .waddr  (stage_q.addr),
        .wdata  (stage_q.data),
        .raddr1 (wb.ReadReg1),
        .raddr2 (wb.ReadReg2),
        .rdata1 (arr_rd1),
        .rdata2 (arr_rd2)
    );

    assign zero1 = is_zero_reg(wb.ReadReg1);
    assign zero2 = is_zero_reg(wb.ReadReg2);
    assign hit1  = !zero1 && pend_q && (wb.ReadReg1 == stage_q.addr);
    assign hit2  = !zero2 && pend_q && (wb.ReadReg2 == stage_q.addr);

    always_comb begin
        rd1 = arr_rd1;
        unique case (1'b1)
            zero1:   rd1 = '0;
            hit1:    rd1 = stage_q.data;
            default: rd1 = arr_rd1;
        endcase
    end

    always_comb begin
        rd2 = arr_rd2;
        unique case (1'b1)
            zero2:   rd2 = '0;
            hit2:    rd2 = stage_q.data;
            default: rd2 = arr_rd2;
        endcase
    end

    assign wb.ReadData1 = rd1;
    assign wb.ReadData2 = rd2;
    assign wb.WbPending = pend_q;
    assign wb.WbCount   = cnt_q;

endmodule

// File: tb/tb_write_back_regfile.sv
// Directed bench for write_back_regfile with a reference model and
// an expected-value queue checked against the combinational outputs.
module tb_write_back_regfile;
    import write_back_regfile_pkg::*;

    localparam int CW = 4;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic CLK;
    logic RST;
    int   checks;
    int   errors;
    exp_t sb [$];

    logic [DATA_W-1:0] m_arr [REG_COUNT];
    logic              m_pend;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic [CW-1:0]     m_cnt;

    write_back_regfile_if #(.CNT_WIDTH(CW)) wbi ();

    write_back_regfile #(.CNT_WIDTH(CW)) dut (
        .CLK (CLK),
        .RST (RST),
        .wb  (wbi.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [DATA_W-1:0] m_read(input logic [ADDR_W-1:0] idx);
        if (idx == 0) return '0;
        if (m_pend && idx == m_addr) return m_data;
        return m_arr[idx];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty, got %h", tag, obs);
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s/%s: got %h expected %h", tag, e.tag, obs, e.val);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < REG_COUNT; i++) m_arr[i] = '0;
        m_pend = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_cnt  = '0;
    endtask

    // One cycle: drive at negedge, check pre-edge outputs, advance model.
    task automatic cycle(input logic we, input logic [ADDR_W-1:0] wr,
                         input logic [DATA_W-1:0] wd,
                         input logic [ADDR_W-1:0] r1,
                         input logic [ADDR_W-1:0] r2,
                         input logic rst, input string tag);
        @(negedge CLK);
        RST           = rst;
        wbi.RegWre    = we;
        wbi.WriteReg  = wr;
        wbi.WriteData = wd;
        wbi.ReadReg1  = r1;
        wbi.ReadReg2  = r2;
        sb.push_back('{"rd1", m_read(r1)});
        sb.push_back('{"rd2", m_read(r2)});
        sb.push_back('{"pend", {31'd0, m_pend}});
        sb.push_back('{"cnt", {28'd0, m_cnt}});
        #1;
        check(tag, wbi.ReadData1);
        check(tag, wbi.ReadData2);
        check(tag, {31'd0, wbi.WbPending});
        check(tag, {28'd0, wbi.WbCount});
        if (!rst) begin
            model_reset();
        end else begin
            if (m_pend) begin
                m_arr[m_addr] = m_data;
                m_cnt = m_cnt + 1'b1;
            end
            m_pend = we && (wr != 0);
            if (m_pend) begin
                m_addr = wr;
                m_data = wd;
            end
        end
    endtask

    task automatic direct(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
        sb.push_back('{"direct", exp});
        check(tag, obs);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST           = 1'b0;
        wbi.RegWre    = 1'b0;
        wbi.WriteReg  = '0;
        wbi.WriteData = '0;
        wbi.ReadReg1  = '0;
        wbi.ReadReg2  = '0;
        repeat (2) @(posedge CLK);
        model_reset();

        // Reset state on every index, requests during reset ignored.
        cycle(1, 4, 32'h1234_5678, 4, 4, 0, "rst_req");
        for (int i = 0; i < REG_COUNT; i++) begin
            cycle(0, 0, 0, i[ADDR_W-1:0], 5'(REG_COUNT - 1 - i), 1, "rst_read");
        end

        // Single write: 0 in cycle N, bypass in N+1, array in N+2.
        cycle(1, 5, 32'hDEAD_BEEF, 5, 0, 1, "w5_n");
        direct("w5_n_rd1", wbi.ReadData1, 32'h0);
        cycle(0, 0, 0, 5, 5, 1, "w5_n1");
        direct("w5_n1_rd1", wbi.ReadData1, 32'hDEAD_BEEF);
        direct("w5_n1_pend", {31'd0, wbi.WbPending}, 32'd1);
        cycle(0, 0, 0, 5, 0, 1, "w5_n2");
        direct("w5_n2_rd1", wbi.ReadData1, 32'hDEAD_BEEF);
        direct("w5_n2_cnt", {28'd0, wbi.WbCount}, 32'd1);

        // Back-to-back writes to the same register then another.
        cycle(1, 3, 32'h11, 3, 7, 1, "b2b_a");
        cycle(1, 3, 32'h22, 3, 7, 1, "b2b_b");
        direct("b2b_bypass1", wbi.ReadData1, 32'h11);
        cycle(1, 7, 32'h33, 3, 7, 1, "b2b_c");
        direct("b2b_bypass2", wbi.ReadData1, 32'h22);
        cycle(0, 0, 0, 3, 7, 1, "b2b_d");
        cycle(0, 0, 0, 3, 7, 1, "b2b_e");
        direct("b2b_arr3", wbi.ReadData1, 32'h22);
        direct("b2b_arr7", wbi.ReadData2, 32'h33);
        direct("b2b_cnt", {28'd0, wbi.WbCount}, 32'd4);

        // Writes to register 0 are dropped entirely.
        cycle(1, 0, 32'hFFFF_FFFF, 0, 0, 1, "z_req");
        cycle(0, 0, 0, 0, 3, 1, "z_after");
        direct("z_pend", {31'd0, wbi.WbPending}, 32'd0);
        direct("z_rd0", wbi.ReadData1, 32'h0);
        direct("z_cnt", {28'd0, wbi.WbCount}, 32'd4);

        // Pending write discarded by reset.
        cycle(1, 9, 32'hA5A5_A5A5, 9, 9, 1, "rw_req");
        cycle(0, 0, 0, 9, 9, 0, "rw_rst");
        direct("rw_bypass", wbi.ReadData1, 32'hA5A5_A5A5);
        cycle(0, 0, 0, 9, 5, 1, "rw_after");
        direct("rw_rd9", wbi.ReadData1, 32'h0);
        direct("rw_rd5", wbi.ReadData2, 32'h0);
        direct("rw_pend", {31'd0, wbi.WbPending}, 32'd0);
        direct("rw_cnt", {28'd0, wbi.WbCount}, 32'd0);

        // Counter wrap: 15 commits then one more returns to zero.
        for (int i = 1; i <= 15; i++) begin
            cycle(1, 5'(i), 32'hC000_0000 | i, 5'(i), 5'(i - 1), 1, "wrap_w");
        end
        cycle(0, 0, 0, 15, 14, 1, "wrap_15a");
        cycle(0, 0, 0, 1, 8, 1, "wrap_15b");
        direct("wrap_15", {28'd0, wbi.WbCount}, 32'd15);
        direct("wrap_arr1", wbi.ReadData1, 32'hC000_0001);
        cycle(1, 20, 32'h0BAD_F00D, 20, 15, 1, "wrap_last");
        cycle(0, 0, 0, 20, 15, 1, "wrap_pend");
        cycle(0, 0, 0, 20, 15, 1, "wrap_done");
        direct("wrap_0", {28'd0, wbi.WbCount}, 32'd0);
        direct("wrap_arr20", wbi.ReadData1, 32'h0BAD_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
